scale_wr_burst: RTL and testbench
=================================

SCALE_WR_BURST -- requirements
Module: scale_wr_burst

Interface
REQ-001 Parameter PIX_WIDTH, default 16, pixel width in bits.
REQ-002 Parameter BURST_LEN, default 16, maximum words per DDR3 write burst.
REQ-003 Parameter FIFO_DEPTH, default 64, packed-word buffer depth (power of two).
REQ-004 Parameter LINE_PITCH, default 640, DDR3 line stride in pixel-address units.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 frame_start  in  1  one-cycle pulse; latches geometry and starts a frame.
REQ-008 base_addr  in  28  frame base address, pixel units; sampled at frame_start.
REQ-009 TARGET_H_NUM  in  13  pixels per line (1..4095); sampled at frame_start.
REQ-010 TARGET_V_NUM  in  13  lines per frame (1..4095); sampled at frame_start.
REQ-011 pix_data  in  PIX_WIDTH  scaled pixel from scaler.
REQ-012 data_vaild  in  1  pix_data valid this cycle.
REQ-013 wr_req  out  1  burst request to DDR3 controller.
REQ-014 wr_ack  in  1  controller accepts request.
REQ-015 wr_addr  out  28  burst start address, pixel units.
REQ-016 wr_len  out  8  words in burst (1..BURST_LEN).
REQ-017 wr_data_en  in  1  controller pops one word this cycle.
REQ-018 wr_data  out  8*PIX_WIDTH  head word, valid while wr_data_en high.
REQ-019 frame_done  out  1  one-cycle pulse after final burst of frame.
REQ-020 ovf  out  1  sticky error: FIFO overflow or pop while empty; cleared by frame_start.

Function
REQ-021 Before the first frame_start, and after frame_done, data_vaild is ignored.
REQ-022 Packer: pixel k (0..7) of a word occupies bits [16k+15:16k]; first pixel in LSBs.
REQ-023 A word is pushed when 8 pixels collected or the line's last pixel arrives; unused lanes zero.
REQ-024 Words per line W = ceil(TARGET_H_NUM/8); packer column counter wraps at TARGET_H_NUM.
REQ-025 FIFO is show-ahead: wr_data equals head word combinationally, no pop latency.
REQ-026 Writer states IDLE, REQ, DATA, DONE; reset state IDLE.
REQ-027 IDLE->REQ when frame active and FIFO count >= L, L = min(BURST_LEN, W - word_idx).
REQ-028 In REQ: wr_req=1, wr_addr = base + row*LINE_PITCH + word_idx*8, wr_len = L, all stable until wr_ack.
REQ-029 REQ->DATA on cycle wr_ack=1 sampled; wr_req low from next cycle.
REQ-030 DATA: each wr_data_en pops one word; after L pops, word_idx += L.
REQ-031 Bursts never cross a line; at word_idx = W, word_idx=0 and row += 1.
REQ-032 DATA->IDLE after L pops; DATA->DONE if that burst ends row TARGET_V_NUM-1.
REQ-033 DONE: frame_done=1 for one cycle, then IDLE with frame inactive.
REQ-034 Push while FIFO full: word dropped, ovf=1; wr_data_en while empty: no pop, ovf=1.
REQ-035 Simultaneous push and pop on full FIFO: both succeed, no overflow.
REQ-036 frame_start in any state: FIFO flushed, packer/counters cleared, wr_req=0, state IDLE, ovf=0, next cycle.
REQ-037 Address arithmetic 28-bit, wraps modulo 2^28.

Reset
REQ-038 On rstn low: wr_req=0, wr_addr=0, wr_len=0, frame_done=0, ovf=0, FIFO empty, state IDLE, frame inactive; wr_data reads 0.

Structure
REQ-039 Shared package holds writer state encoding, pixels-per-word constant (8) and default parameter values.
REQ-040 One sub-module scale_wr_fifo: synchronous show-ahead FIFO with count, full, empty.

Verification
REQ-041 H=640,V=360,base=0x38400, immediate ack/en -> 5 bursts/line len 16; line 1 first addr 0x38680; frame_done after 1800 bursts.
REQ-042 H=100,V=2 -> one burst per line len 13; last word bits 127:64 zero; second line addr base+640.
REQ-043 wr_ack delayed 10 cycles -> wr_req, wr_addr, wr_len held constant all 10 cycles.
REQ-044 wr_data_en held low, 65 words pushed -> ovf=1, 64 words retained, word 65 lost.
REQ-045 frame_start asserted mid-DATA -> next cycle wr_req=0, FIFO empty, state IDLE, ovf=0.
REQ-046 Reset asserted mid-burst -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/scale_wr_burst_pkg.sv
// Shared constants, writer state encoding and burst command payload for the
// scaled-frame DDR3 write path.
package scale_wr_burst_pkg;

    localparam int unsigned PIX_PER_WORD   = 8;
    localparam int unsigned DEF_PIX_WIDTH  = 16;
    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 64;
    localparam int unsigned DEF_LINE_PITCH = 640;
    localparam int unsigned ADDR_W         = 28;
    localparam int unsigned DIM_W          = 13;
    localparam int unsigned LEN_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } wr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } wr_cmd_t;

    // Packed words needed to hold one line of h pixels (ceiling division).
    function automatic logic [DIM_W-1:0] words_per_line(input logic [DIM_W-1:0] h);
        logic [DIM_W:0] t;
        t = {1'b0, h} + (DIM_W+1)'(PIX_PER_WORD - 1);
        return DIM_W'(t / (DIM_W+1)'(PIX_PER_WORD));
    endfunction

endpackage

// File: rtl/scale_wr_burst_if.sv
// DDR3 write-burst channel between the frame writer (master) and the
// memory controller (slave).
interface scale_wr_burst_if #(
    parameter int unsigned PIX_WIDTH = scale_wr_burst_pkg::DEF_PIX_WIDTH
) ();
    import scale_wr_burst_pkg::*;

    logic                              wr_req;
    logic                              wr_ack;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [LEN_W-1:0]                  wr_len;
    logic                              wr_data_en;
    logic [PIX_PER_WORD*PIX_WIDTH-1:0] wr_data;

    modport master (output wr_req, wr_addr, wr_len, wr_data,
                    input  wr_ack, wr_data_en);
    modport slave  (input  wr_req, wr_addr, wr_len, wr_data,
                    output wr_ack, wr_data_en);
endinterface

// File: rtl/scale_wr_burst_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata_o without a
// pop cycle; reads zero while empty.
module scale_wr_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    // A pop frees the slot, so a push into a full FIFO succeeds alongside it.
    always_comb begin
        do_pop  = pop_i & ~empty_q;
        do_push = push_i & (~full_q | do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

// File: rtl/scale_wr_burst.sv
// Packs scaled pixels into 8-pixel words and writes each frame line to DDR3
// as bursts of at most BURST_LEN words that never cross a line boundary.
module scale_wr_burst #(
    parameter int unsigned PIX_WIDTH  = scale_wr_burst_pkg::DEF_PIX_WIDTH,
    parameter int unsigned BURST_LEN  = scale_wr_burst_pkg::DEF_BURST_LEN,
    parameter int unsigned FIFO_DEPTH = scale_wr_burst_pkg::DEF_FIFO_DEPTH,
    parameter int unsigned LINE_PITCH = scale_wr_burst_pkg::DEF_LINE_PITCH
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 frame_start,
    input  logic [scale_wr_burst_pkg::ADDR_W-1:0] base_addr,
    input  logic [scale_wr_burst_pkg::DIM_W-1:0]  TARGET_H_NUM,
    input  logic [scale_wr_burst_pkg::DIM_W-1:0]  TARGET_V_NUM,
    input  logic [PIX_WIDTH-1:0]                 pix_data,
    input  logic                                 data_vaild,
    scale_wr_burst_if.master                     wr_bus,
    output logic                                 frame_done,
    output logic                                 ovf
);
    import scale_wr_burst_pkg::*;

    localparam int unsigned WORD_W = PIX_PER_WORD * PIX_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LANE_W = $clog2(PIX_PER_WORD);

    wr_state_e         state_q;
    wr_cmd_t           cmd_q;
    logic              frame_active_q, wr_req_q, frame_done_q, ovf_q;
    logic [ADDR_W-1:0] base_q;
    logic [DIM_W-1:0]  h_q, v_q, col_q, word_idx_q, row_q;
    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] pack_q, pack_word_c;
    logic [LEN_W-1:0]  pop_cnt_q;

    logic              pix_take_c, line_end_c, word_done_c, push_c, pop_c, err_c;
    logic [DIM_W-1:0]  wpl_c, rem_c, burst_end_c;
    logic [LEN_W-1:0]  burst_len_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic [WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;

    always_comb begin
        pix_take_c  = frame_active_q & data_vaild & ~frame_start;
        line_end_c  = (col_q == DIM_W'(h_q - DIM_W'(1)));
        word_done_c = (lane_q == LANE_W'(PIX_PER_WORD - 1)) | line_end_c;
        push_c      = pix_take_c & word_done_c;
        pop_c       = wr_bus.wr_data_en & (state_q == ST_DATA) & ~frame_start;
        err_c       = (push_c & fifo_full & ~pop_c) | (wr_bus.wr_data_en & fifo_empty);
        pack_word_c = pack_q;
        pack_word_c[32'(lane_q) * PIX_WIDTH +: PIX_WIDTH] = pix_data;
    end

    // Next burst geometry: clipped to the words left in the current line.
    always_comb begin
        wpl_c       = words_per_line(h_q);
        rem_c       = wpl_c - word_idx_q;
        burst_len_c = (rem_c > DIM_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(rem_c);
        req_addr_c  = base_q + ADDR_W'(row_q) * ADDR_W'(LINE_PITCH)
                             + ADDR_W'(word_idx_q) * ADDR_W'(PIX_PER_WORD);
        burst_end_c = word_idx_q + DIM_W'(cmd_q.len);
    end

    scale_wr_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (frame_start),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (pack_word_c),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pixel packer: first pixel of a word lands in the low lane.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q  <= '0;
            lane_q <= '0;
            pack_q <= '0;
        end else if (frame_start) begin
            col_q  <= '0;
            lane_q <= '0;
            pack_q <= '0;
        end else if (pix_take_c) begin
            if (word_done_c) begin
                pack_q <= '0;
                lane_q <= '0;
            end else begin
                pack_q <= pack_word_c;
                lane_q <= lane_q + LANE_W'(1);
            end
            col_q <= line_end_c ? '0 : col_q + DIM_W'(1);
        end
    end

    // Burst writer FSM with registered request and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            frame_active_q <= 1'b0;
            wr_req_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            ovf_q          <= 1'b0;
            base_q         <= '0;
            h_q            <= '0;
            v_q            <= '0;
            word_idx_q     <= '0;
            row_q          <= '0;
            pop_cnt_q      <= '0;
        end else if (frame_start) begin
            state_q        <= ST_IDLE;
            frame_active_q <= 1'b1;
            wr_req_q       <= 1'b0;
            frame_done_q   <= 1'b0;
            ovf_q          <= 1'b0;
            base_q         <= base_addr;
            h_q            <= TARGET_H_NUM;
            v_q            <= TARGET_V_NUM;
            word_idx_q     <= '0;
            row_q          <= '0;
            pop_cnt_q      <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (err_c) ovf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (frame_active_q && (DIM_W'(fifo_count) >= DIM_W'(burst_len_c))) begin
                        cmd_q     <= '{addr: req_addr_c, len: burst_len_c};
                        wr_req_q  <= 1'b1;
                        pop_cnt_q <= '0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wr_bus.wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (pop_c && !fifo_empty) begin
                        pop_cnt_q <= pop_cnt_q + LEN_W'(1);
                        if (LEN_W'(pop_cnt_q + LEN_W'(1)) == cmd_q.len) begin
                            if (burst_end_c == wpl_c) begin
                                word_idx_q <= '0;
                                row_q      <= row_q + DIM_W'(1);
                                if (row_q == DIM_W'(v_q - DIM_W'(1))) begin
                                    frame_done_q <= 1'b1;
                                    state_q      <= ST_DONE;
                                end else begin
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                word_idx_q <= burst_end_c;
                                state_q    <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    frame_active_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_bus.wr_req  = wr_req_q;
    assign wr_bus.wr_addr = cmd_q.addr;
    assign wr_bus.wr_len  = cmd_q.len;
    assign wr_bus.wr_data = fifo_head;
    assign frame_done     = frame_done_q;
    assign ovf            = ovf_q;
endmodule

// File: tb/tb_scale_wr_burst.sv
// Directed/randomized bench for scale_wr_burst: a frame-level model predicts
// every burst address, length and packed data word.
module tb_scale_wr_burst;

    logic        clk;
    logic        rstn;
    logic        frame_start;
    logic [27:0] base_addr;
    logic [12:0] h_num, v_num;
    logic [15:0] pix_data;
    logic        data_vaild;
    logic        frame_done, ovf;

    scale_wr_burst_if #(.PIX_WIDTH(16)) bus ();

    scale_wr_burst dut (
        .clk          (clk),
        .rstn         (rstn),
        .frame_start  (frame_start),
        .base_addr    (base_addr),
        .TARGET_H_NUM (h_num),
        .TARGET_V_NUM (v_num),
        .pix_data     (pix_data),
        .data_vaild   (data_vaild),
        .wr_bus       (bus.master),
        .frame_done   (frame_done),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp, n_bad;
    bit           hung;
    logic [15:0]  px[$];
    logic [127:0] exp_words[$];
    logic [27:0]  exp_addr[$];
    int           exp_len[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame model: pixels in raster order, 8 per word, lines padded with zero lanes,
    // each line split into bursts of at most 16 words at base + row*640 + word*8.
    task automatic build_model(input logic [27:0] base, input int h, input int v);
        int w;
        logic [127:0] word;
        exp_words.delete(); exp_addr.delete(); exp_len.delete();
        w = (h + 7) / 8;
        for (int r = 0; r < v; r++) begin
            for (int j = 0; j < w; j++) begin
                word = '0;
                for (int k = 0; k < 8; k++)
                    if (8*j + k < h) word = word | (128'(px[r*h + 8*j + k]) << (16*k));
                exp_words.push_back(word);
            end
            for (int j = 0; j < w; j += 16) begin
                exp_addr.push_back(base + 28'(r*640 + j*8));
                exp_len.push_back((w - j) < 16 ? (w - j) : 16);
            end
        end
    endtask

    task automatic start_frame(input logic [27:0] base, input int h, input int v);
        px.delete();
        for (int i = 0; i < h*v; i++) px.push_back(16'($urandom));
        build_model(base, h, v);
        frame_start = 1'b1; base_addr = base; h_num = 13'(h); v_num = 13'(v);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            data_vaild = 1'b1; pix_data = px[first + i];
            @(negedge clk);
            data_vaild = 1'b0;
        end
    endtask

    task automatic feed_junk(input int n);
        for (int i = 0; i < n; i++) begin
            data_vaild = 1'b1; pix_data = 16'($urandom);
            @(negedge clk);
        end
        data_vaild = 1'b0;
    endtask

    task automatic expect_idle(input int n, input string tag);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.wr_req) seen = 1'b1;
        end
        check(tag, 128'(seen), 128'(0));
    endtask

    // Acts as the DDR3 controller for one burst; pops npop words.
    task automatic serve_burst(input logic [27:0] addr, input int len, input int ack_dly,
                               input int gap, input bit last, input int npop);
        bit got = 1'b0;
        if (hung) return;
        for (int t = 0; t < 1000 && !got; t++) begin
            if (bus.wr_req === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        check("req_seen", 128'(got), 128'(1));
        if (!got) begin hung = 1'b1; return; end
        check("wr_addr", 128'(bus.wr_addr), 128'(addr));
        check("wr_len", 128'(bus.wr_len), 128'(len));
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            check("req_hold", 128'(bus.wr_req), 128'(1));
            check("addr_hold", 128'(bus.wr_addr), 128'(addr));
            check("len_hold", 128'(bus.wr_len), 128'(len));
        end
        bus.wr_ack = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        check("req_drop", 128'(bus.wr_req), 128'(0));
        for (int i = 0; i < npop; i++) begin
            repeat ($urandom_range(0, gap)) @(negedge clk);
            bus.wr_data_en = 1'b1;
            check("wr_data", bus.wr_data, exp_words.size() > 0 ? exp_words.pop_front() : 128'(0));
            @(negedge clk);
            bus.wr_data_en = 1'b0;
        end
        if (npop == len) check("frame_done", 128'(frame_done), 128'(last));
    endtask

    task automatic run_frame(input logic [27:0] base, input int h, input int v, input int ack_min,
                             input int ack_max, input int gap, input int pix_gap);
        int nb;
        start_frame(base, h, v);
        nb = exp_addr.size();
        fork
            feed(0, h*v, pix_gap);
            for (int b = 0; b < nb; b++)
                serve_burst(exp_addr[b], exp_len[b], $urandom_range(ack_min, ack_max), gap,
                            b == nb - 1, exp_len[b]);
        join
        check("ovf_clean", 128'(ovf), 128'(0));
        check("words_left", 128'(exp_words.size()), 128'(0));
        feed_junk(16);
        expect_idle(10, "ignored_after_done");
    endtask

    task automatic pulse_en_empty();
        bus.wr_data_en = 1'b1;
        @(negedge clk);
        bus.wr_data_en = 1'b0;
        check("ovf_pop_empty", 128'(ovf), 128'(1));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; hung = 1'b0;
        rstn = 1'b0; frame_start = 1'b0; base_addr = '0; h_num = '0; v_num = '0;
        pix_data = '0; data_vaild = 1'b0; bus.wr_ack = 1'b0; bus.wr_data_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_req", 128'(bus.wr_req), 128'(0));
        check("rst_wr_addr", 128'(bus.wr_addr), 128'(0));
        check("rst_wr_len", 128'(bus.wr_len), 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        check("rst_ovf", 128'(ovf), 128'(0));
        check("rst_wr_data", bus.wr_data, 128'(0));
        rstn = 1'b1;
        @(negedge clk);

        // Pixels before any frame_start are ignored.
        feed_junk(24);
        expect_idle(10, "pre_frame_idle");
        check("pre_frame_data", bus.wr_data, 128'(0));

        run_frame(28'h0012340, 100, 2, 0, 3, 2, 2);
        run_frame(28'h0038400, 640, 3, 0, 0, 0, 0);
        run_frame(28'hFFFFF80, 8, 3, 0, 2, 1, 1);
        run_frame(28'($urandom), 1, 2, 0, 2, 1, 1);
        for (int i = 0; i < 3; i++)
            run_frame(28'($urandom), $urandom_range(1, 70), $urandom_range(1, 3), 0, 3, 2, 2);
        run_frame(28'h0000800, 20, 2, 10, 10, 1, 1);

        // Overflow: no pops while 65 words arrive.
        start_frame(28'h0100000, 640, 1);
        feed(0, 512, 0);
        check("ovf_at_64", 128'(ovf), 128'(0));
        check("req_while_full", 128'(bus.wr_req), 128'(1));
        feed(512, 8, 0);
        check("ovf_at_65", 128'(ovf), 128'(1));
        for (int b = 0; b < 4; b++) serve_burst(exp_addr[b], 16, 0, 0, 1'b0, 16);
        check("word65_lost", bus.wr_data, 128'(0));
        expect_idle(20, "no_req_after_64");
        check("ovf_sticky", 128'(ovf), 128'(1));

        // frame_start in the middle of a data phase.
        start_frame(28'h0200000, 64, 2);
        pulse_en_empty();
        feed(0, 64, 0);
        serve_burst(exp_addr[0], 8, 0, 0, 1'b0, 3);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("abort_wr_req", 128'(bus.wr_req), 128'(0));
        check("abort_fifo_empty", bus.wr_data, 128'(0));
        check("abort_ovf", 128'(ovf), 128'(0));
        expect_idle(8, "abort_idle");
        run_frame(28'h0300000, 24, 2, 0, 2, 1, 1);

        // Asynchronous reset during a data phase.
        start_frame(28'h1234567, 32, 1);
        pulse_en_empty();
        feed(0, 32, 0);
        serve_burst(exp_addr[0], 4, 0, 0, 1'b0, 2);
        #3 rstn = 1'b0;
        #1;
        check("arst_wr_req", 128'(bus.wr_req), 128'(0));
        check("arst_wr_addr", 128'(bus.wr_addr), 128'(0));
        check("arst_wr_len", 128'(bus.wr_len), 128'(0));
        check("arst_frame_done", 128'(frame_done), 128'(0));
        check("arst_ovf", 128'(ovf), 128'(0));
        check("arst_wr_data", bus.wr_data, 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        feed_junk(40);
        expect_idle(10, "post_reset_inactive");
        run_frame(28'h0400000, 48, 2, 0, 3, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
